// File: rtl/f5_sweep_ctrl.sv
// Sweep sequencer that walks every minterm of the f5 function, samples two implementations and logs disagreements.
// Optional macro F5_GOLDEN_CHECK_EN also compares implementation A against the GOLDEN truth table.
module f5_sweep_ctrl #(
    parameter int                NIN    = 2,
    parameter int                SETTLE = 1,
    parameter logic [2**NIN-1:0] GOLDEN = 4'b0010
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [NIN-1:0]     stim,
    input  logic               a_in,
    input  logic               b_in,
    output logic               busy,
    output logic               done,
    output logic [2**NIN-1:0]  mismatch,
    output logic [2**NIN-1:0]  golden_mask,
    output logic [NIN:0]       err_count,
    output logic               pass
);

    localparam int NM = 2**NIN;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [NIN:0] LAST = (NIN+1)'(NM - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [NIN:0]    m_q, m_d;
    logic [NIN-1:0]  stim_q, stim_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NM-1:0]   mis_q, mis_d;
    logic [NM-1:0]   gold_q, gold_d;
    logic [NIN:0]    err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            stim_q  <= '0;
            cnt_q   <= '0;
            mis_q   <= '0;
            gold_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            gold_q  <= gold_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        gold_d  = gold_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mis_d   = '0;
                    gold_d  = '0;
                    err_d   = '0;
                    m_d     = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                stim_d = m_q[NIN-1:0];
                if (SETTLE == 0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d   = CW'(SETTLE);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q <= CW'(1)) state_d = S_SAMPLE;
                else                 cnt_d   = cnt_q - CW'(1);
            end
            S_SAMPLE: begin
                if (a_in != b_in) begin
                    mis_d[m_q[NIN-1:0]] = 1'b1;
                    err_d               = err_q + (NIN+1)'(1);
                end
`ifdef F5_GOLDEN_CHECK_EN
                if (a_in != GOLDEN[m_q[NIN-1:0]]) gold_d[m_q[NIN-1:0]] = 1'b1;
`endif
                // m is one bit wider than the index so LAST never aliases to 0.
                if (m_q == LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    m_d     = m_q + (NIN+1)'(1);
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stim      = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mismatch  = mis_q;
    assign err_count = err_q;
`ifdef F5_GOLDEN_CHECK_EN
    assign golden_mask = gold_q;
`else
    assign golden_mask = '0;
`endif
    assign pass = done_q & (mis_q == '0) & (golden_mask == '0);

endmodule

// File: tb/tb_f5_sweep_ctrl.sv
// Scoreboard bench for f5_sweep_ctrl: stimulus queues expected sweep results, a monitor checks them at done.
module tb_f5_sweep_ctrl;

    localparam int NIN = 2;
    localparam int NM  = 4;

    typedef struct packed {
        logic [NM-1:0]  mis;
        logic [NM-1:0]  gold;
        logic [NIN:0]   err;
        logic           pass;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [NIN-1:0] stim;
    logic           a_in, b_in;
    logic           busy, done, pass;
    logic [NM-1:0]  mismatch, golden_mask;
    logic [NIN:0]   err_count;

    int checks = 0;
    int failures = 0;
    int mode_a = 0;   // 0: ~a&b, 1: stuck 0, 2: stuck 1
    int mode_b = 0;
    exp_t exp_q[$];

    f5_sweep_ctrl #(.NIN(2), .SETTLE(1), .GOLDEN(4'b0010)) dut (
        .clk(clk), .reset(reset), .start(start), .stim(stim),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .mismatch(mismatch), .golden_mask(golden_mask),
        .err_count(err_count), .pass(pass)
    );

    always #5 clk = ~clk;

    function automatic logic impl(input int mode, input logic [1:0] s);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ~s[1] & s[0];
        endcase
    endfunction

    always_comb a_in = impl(mode_a, stim);
    always_comb b_in = impl(mode_b, stim);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: tracks each sweep from start acceptance and compares at done.
    bit tracking = 0;
    int cyc = 0;
    always @(negedge clk) begin
        if (reset) begin
            tracking = 0;
        end else if (busy && !tracking) begin
            tracking = 1;
            cyc = 0;
        end else if (tracking) begin
            cyc++;
            if (cyc == 2 || cyc == 5 || cyc == 8 || cyc == 11)
                check("stim_seq", 32'(stim), 32'((cyc - 2) / 3));
            if (done) begin
                exp_t e;
                tracking = 0;
                check("done_latency", 32'(cyc), 32'd12);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    check("mismatch", 32'(mismatch), 32'(e.mis));
                    check("golden_mask", 32'(golden_mask), 32'(e.gold));
                    check("err_count", 32'(err_count), 32'(e.err));
                    check("pass", 32'(pass), 32'(e.pass));
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("stim_hold", 32'(stim), 32'd3);
                end
            end else if (cyc > 12) begin
                tracking = 0;
                checks++;
                failures++;
                $display("FAIL done_timeout actual=%0d required=12", cyc);
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_done actual=timeout required=done");
        end
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_stim"}, 32'(stim), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
        check({tag, "_golden"}, 32'(golden_mask), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
    endtask

    initial begin
        // Reset state
        @(posedge clk); #3 reset = 1'b1;
        #1 check_cleared("reset_init");
        @(posedge clk); #1 reset = 1'b0;

        // Both implementations correct
        mode_a = 0; mode_b = 0;
        exp_q.push_back('{mis: 4'b0000, gold: 4'b0000, err: 3'd0, pass: 1'b1});
        do_start();
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done();

        // B stuck at 0
        mode_b = 1;
        exp_q.push_back('{mis: 4'b0010, gold: 4'b0000, err: 3'd1, pass: 1'b0});
        do_start();
        wait_done();

        // Mid-cycle reset clears results without a clock edge
        @(posedge clk); #3 reset = 1'b1;
        #1 check_cleared("reset_async");
        @(posedge clk); #1 reset = 1'b0;

        // start pulses at cycles 3 and 7 are ignored
        mode_b = 0;
        exp_q.push_back('{mis: 4'b0000, gold: 4'b0000, err: 3'd0, pass: 1'b1});
        do_start();
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_mid_sweep", 32'(busy), 32'd1);
        wait_done();

        // Reset at cycle 5 aborts; following sweep completes normally
        mode_b = 1;
        do_start();
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_cleared("reset_mid_sweep");
        @(posedge clk); #1 reset = 1'b0;
        exp_q.push_back('{mis: 4'b0010, gold: 4'b0000, err: 3'd1, pass: 1'b0});
        do_start();
        wait_done();

        // Both stuck at 1
        mode_a = 2; mode_b = 2;
`ifdef F5_GOLDEN_CHECK_EN
        exp_q.push_back('{mis: 4'b0000, gold: 4'b1101, err: 3'd0, pass: 1'b0});
`else
        exp_q.push_back('{mis: 4'b0000, gold: 4'b0000, err: 3'd0, pass: 1'b1});
`endif
        do_start();
        wait_done();

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
